// File: rtl/corner_locator.sv
// corner_locator: finds, per image quadrant, the marker pixel nearest the outer corner and publishes the four corners at frame end.
// Define CORNER_SMOOTH_EN to average each new corner with the previously published one.
module corner_locator #(
  parameter int         H_ACTIVE = 800,
  parameter int         V_ACTIVE = 600,
  parameter logic [9:0] R_MIN    = 10'd640,
  parameter logic [9:0] GB_MAX   = 10'd256,
  parameter int         MIN_HITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_pause,
  output logic        o_addr_valid,
  output logic        o_enable,
  output logic [19:0] o_ul_addr,
  output logic [19:0] o_ur_addr,
  output logic [19:0] o_dl_addr,
  output logic [19:0] o_dr_addr
);
  localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] COL_HALF = 10'(H_ACTIVE / 2);
  localparam logic [9:0] ROW_HALF = 10'(V_ACTIVE / 2);
  localparam logic [7:0] HIT_MIN  = 8'(MIN_HITS);
  typedef enum logic {SCAN, PUBLISH} state_t;
  state_t      r_state, w_next;
  logic        r_paused;
  logic [9:0]  r_row, r_col;
  logic [10:0] r_best_d [4];
  logic [19:0] r_best_a [4];
  logic [7:0]  r_hits [4];
  logic [19:0] r_addr [4];
  logic [10:0] w_dist [4];
  logic [10:0] w_nd [4];
  logic [19:0] w_na [4];
  logic [19:0] w_pub [4];
  logic [7:0]  w_nh [4];
  logic [3:0]  w_hit, w_better;
  logic [1:0]  w_q;
  logic [10:0] w_row, w_col, w_row_inv, w_col_inv;
  logic        w_marker, w_end, w_found;
`ifdef CORNER_SMOOTH_EN
  function automatic logic [9:0] avg(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10:1];
  endfunction
`endif
  assign o_ul_addr = r_addr[0];
  assign o_ur_addr = r_addr[1];
  assign o_dl_addr = r_addr[2];
  assign o_dr_addr = r_addr[3];
  // Quadrant index is {bottom, right}: UL=0, UR=1, DL=2, DR=3.
  always_comb begin
    w_marker  = i_valid && i_data[29:20] >= R_MIN && i_data[19:10] < GB_MAX && i_data[9:0] < GB_MAX;
    w_end     = i_valid && r_row == ROW_LAST && r_col == COL_LAST;
    w_q       = {r_row >= ROW_HALF, r_col >= COL_HALF};
    w_row     = {1'b0, r_row};
    w_col     = {1'b0, r_col};
    w_row_inv = {1'b0, ROW_LAST - r_row};
    w_col_inv = {1'b0, COL_LAST - r_col};
    w_dist[0] = w_row + w_col;
    w_dist[1] = w_row + w_col_inv;
    w_dist[2] = w_row_inv + w_col;
    w_dist[3] = w_row_inv + w_col_inv;
    w_found   = 1'b1;
    for (int q = 0; q < 4; q++) begin
      w_hit[q]    = w_marker && w_q == 2'(q);
      w_better[q] = w_hit[q] && w_dist[q] < r_best_d[q];
      w_nd[q]     = w_better[q] ? w_dist[q] : r_best_d[q];
      w_na[q]     = w_better[q] ? {r_row, r_col} : r_best_a[q];
      w_nh[q]     = (w_hit[q] && r_hits[q] != 8'hFF) ? r_hits[q] + 8'd1 : r_hits[q];
      w_found     = w_found && w_nh[q] >= HIT_MIN;
`ifdef CORNER_SMOOTH_EN
      w_pub[q]    = o_enable ? {avg(r_addr[q][19:10], w_na[q][19:10]), avg(r_addr[q][9:0], w_na[q][9:0])} : w_na[q];
`else
      w_pub[q]    = w_na[q];
`endif
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= SCAN;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_next;
      if (w_end) r_paused <= i_pause;
    end
  end
  always_comb begin
    w_next       = (r_state == SCAN && w_end) ? PUBLISH : SCAN;
    o_addr_valid = r_state == PUBLISH && !r_paused;
  end
  // Trackers restart on the frame-end edge while the results including the last pixel are published.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row    <= '0;
      r_col    <= '0;
      o_enable <= 1'b0;
      for (int q = 0; q < 4; q++) begin
        r_best_d[q] <= '1;
        r_best_a[q] <= '0;
        r_hits[q]   <= '0;
        r_addr[q]   <= '0;
      end
    end else begin
      if (i_valid) begin
        r_col <= r_col == COL_LAST ? '0 : r_col + 10'd1;
        if (r_col == COL_LAST) r_row <= r_row == ROW_LAST ? '0 : r_row + 10'd1;
      end
      for (int q = 0; q < 4; q++) begin
        r_best_d[q] <= w_end ? '1 : w_nd[q];
        r_best_a[q] <= w_end ? '0 : w_na[q];
        r_hits[q]   <= w_end ? '0 : w_nh[q];
      end
      if (w_end && !i_pause) begin
        o_enable <= w_found;
        if (w_found) for (int q = 0; q < 4; q++) r_addr[q] <= w_pub[q];
      end
    end
  end
endmodule

// File: tb/tb_corner_locator.sv
// tb_corner_locator: directed frames on a reduced 64x40 raster with hand-computed corner results.
module tb_corner_locator;
  localparam int H = 64;
  localparam int V = 40;
  localparam logic [31:0] MK = {2'b0, 10'd640, 10'd255, 10'd255};
`ifdef CORNER_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_pause;
  logic [31:0] i_data;
  logic        o_addr_valid, o_enable;
  logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
  int          n_total = 0, n_bad = 0, pulses = 0;
  int          br [4] = '{2, 2, 30, 33};
  int          bc [4] = '{3, 55, 4, 57};
  int          bh [4] = '{5, 5, 5, 5};
  int          bw [4] = '{5, 5, 5, 5};
  int          xr = -1, xc = -1;
  logic        e_pulse = 1'b0, e_en = 1'b0;
  logic [19:0] e_addr [4] = '{20'd0, 20'd0, 20'd0, 20'd0};
  corner_locator #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data), .i_pause(i_pause),
    .o_addr_valid(o_addr_valid), .o_enable(o_enable),
    .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr), .o_dl_addr(o_dl_addr), .o_dr_addr(o_dr_addr)
  );
  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_addr_valid) pulses++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] ad(input int r, input int c);
    return {10'(r), 10'(c)};
  endfunction
  function automatic logic [9:0] avg10(input logic [9:0] a, input logic [9:0] b);
    return 10'((int'(a) + int'(b)) / 2);
  endfunction
  function automatic logic [31:0] pix(input int r, input int c);
    if (r == 0 && c == 0) return {2'b0, 10'd639, 10'd0, 10'd0};
    if (r == 0 && c == H - 1) return {2'b0, 10'd1023, 10'd256, 10'd0};
    if (r == V - 1 && c == 0) return {2'b0, 10'd1023, 10'd0, 10'd256};
    for (int b = 0; b < 4; b++)
      if (r >= br[b] && r < br[b] + bh[b] && c >= bc[b] && c < bc[b] + bw[b]) return MK;
    if (r == xr && c == xc) return MK;
    return 32'd0;
  endfunction
  task automatic model(input bit found, input bit pz, input logic [19:0] n0, input logic [19:0] n1,
                       input logic [19:0] n2, input logic [19:0] n3);
    logic [19:0] n [4];
    n = '{n0, n1, n2, n3};
    e_pulse = !pz;
    if (pz) return;
    if (!found) begin
      e_en = 1'b0;
      return;
    end
    for (int q = 0; q < 4; q++)
      e_addr[q] = (SMOOTH && e_en) ? {avg10(e_addr[q][19:10], n[q][19:10]), avg10(e_addr[q][9:0], n[q][9:0])} : n[q];
    e_en = 1'b1;
  endtask
  task automatic send_frame(input int gap, input bit pz, input int stop);
    int n = 0;
    pulses = 0;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        if (stop >= 0 && n == stop) return;
        while (gap > 0 && $urandom_range(99) < gap) begin
          i_valid = 1'b0;
          i_data  = MK;
          @(posedge i_clk); #1;
        end
        i_valid = 1'b1;
        i_data  = pix(r, c);
        i_pause = pz && r == V - 1 && c == H - 1;
        @(posedge i_clk); #1;
        n++;
      end
    i_valid = 1'b0;
    i_pause = 1'b0;
  endtask
  task automatic verify(input string t);
    chk({t, "_pulse"}, 32'(o_addr_valid), 32'(e_pulse));
    chk({t, "_en"}, 32'(o_enable), 32'(e_en));
    chk({t, "_ul"}, 32'(o_ul_addr), 32'(e_addr[0]));
    chk({t, "_ur"}, 32'(o_ur_addr), 32'(e_addr[1]));
    chk({t, "_dl"}, 32'(o_dl_addr), 32'(e_addr[2]));
    chk({t, "_dr"}, 32'(o_dr_addr), 32'(e_addr[3]));
    @(posedge i_clk); #1;
    chk({t, "_after"}, 32'(o_addr_valid), 32'd0);
    chk({t, "_cnt"}, 32'(pulses), 32'(e_pulse));
  endtask
  initial begin
    logic [19:0] t_ul, t_ur, t_dl, t_dr;
    t_ul = ad(2, 3);
    t_ur = ad(2, 59);
    t_dl = ad(34, 4);
    t_dr = ad(37, 61);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_pause = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_addr_valid), 32'd0);
    chk("rst_en", 32'(o_enable), 32'd0);
    chk("rst_ul", 32'(o_ul_addr), 32'd0);
    chk("rst_dr", 32'(o_dr_addr), 32'd0);
    i_rst_n = 1'b1;
    bh = '{0, 0, 0, 0};
    send_frame(0, 1'b0, -1);
    model(1'b0, 1'b0, 20'd0, 20'd0, 20'd0, 20'd0);
    verify("black");
    bh = '{5, 5, 5, 5};
    send_frame(0, 1'b0, -1);
    model(1'b1, 1'b0, t_ul, t_ur, t_dl, t_dr);
    verify("blocks");
    bh[3] = 3;
    send_frame(0, 1'b0, -1);
    model(1'b0, 1'b0, t_ul, t_ur, t_dl, t_dr);
    verify("hits15");
    xr = V - 1;
    xc = H - 1;
    send_frame(0, 1'b0, -1);
    model(1'b1, 1'b0, t_ul, t_ur, t_dl, ad(39, 63));
    verify("hits16");
    xr = -1;
    bh[3] = 5;
    send_frame(0, 1'b1, -1);
    model(1'b1, 1'b1, t_ul, t_ur, t_dl, t_dr);
    verify("paused");
    send_frame(0, 1'b0, -1);
    model(1'b1, 1'b0, t_ul, t_ur, t_dl, t_dr);
    verify("unpaused");
    send_frame(50, 1'b0, -1);
    model(1'b1, 1'b0, t_ul, t_ur, t_dl, t_dr);
    verify("gaps");
    send_frame(0, 1'b0, 1000);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    e_en   = 1'b0;
    e_addr = '{20'd0, 20'd0, 20'd0, 20'd0};
    chk("midrst_valid", 32'(o_addr_valid), 32'd0);
    chk("midrst_en", 32'(o_enable), 32'd0);
    chk("midrst_ul", 32'(o_ul_addr), 32'd0);
    chk("midrst_ur", 32'(o_ur_addr), 32'd0);
    chk("midrst_dl", 32'(o_dl_addr), 32'd0);
    chk("midrst_dr", 32'(o_dr_addr), 32'd0);
    #2 i_rst_n = 1'b1;
    send_frame(0, 1'b0, -1);
    model(1'b1, 1'b0, t_ul, t_ur, t_dl, t_dr);
    verify("post_rst");
    br[0] = 6;
    bc[0] = 9;
    send_frame(0, 1'b0, -1);
    model(1'b1, 1'b0, ad(6, 9), t_ur, t_dl, t_dr);
    verify("moved");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
